// File: rtl/wbdepp_burst_if.sv
// -----------------------------------------------------------------------------
// wbdepp_burst_if
//   Pipelined Wishbone bus between the DEPP burst bridge (master) and the
//   FPGA interconnect (slave). Signal names are taken from the master's view:
//   o_wb_* are driven by the master, i_wb_* are driven by the slave.
//
//   o_wb_cyc    cycle in progress
//   o_wb_stb    request strobe
//   o_wb_we     1 = write, 0 = read
//   o_wb_addr   word address, AW bits
//   o_wb_data   write data, DW bits
//   i_wb_ack    transfer acknowledge
//   i_wb_stall  slave cannot take the request this clock
//   i_wb_err    transfer error
//   i_wb_data   read data, DW bits
// -----------------------------------------------------------------------------
interface wbdepp_burst_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic          i_wb_err;
    logic [DW-1:0] i_wb_data;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/wbdepp_burst.sv
// -----------------------------------------------------------------------------
// wbdepp_burst
//   Host parallel port (PW-bit beats) to pipelined Wishbone master bridge.
//   Address beats shift into the WB address, data beats assemble DW-bit
//   words, and reads return a word as DW/PW beats. Optional address
//   auto-increment after each completed word gives burst access. A sticky
//   error flag and a status byte are readable through an address-strobe read.
//
//   Optional feature macro: WBDEPP_TIMEOUT_EN
//     defined   : bus watchdog ends a WB cycle after TIMEOUT clocks without
//                 ack/err and flags an error
//     undefined : BUS waits for ack/err indefinitely, TIMEOUT has no effect
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_astb_n    host address strobe, active low, asynchronous
//   i_dstb_n    host data strobe, active low, asynchronous
//   i_write_n   0 = host write, 1 = host read, sampled with the strobe
//   i_depp      host write data (PW bits)
//   o_depp      host read data (PW bits)
//   o_wait      beat handshake to host
//   i_int       interrupt, reported in the status byte
//   wb          Wishbone master modport (see wbdepp_burst_if)
//
// Status byte (address read): {0.., beat_cnt!=0, int, err, busy}
// -----------------------------------------------------------------------------
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a host strobe falling edge
//   BUS   | WB cycle open, waiting for ack / err (/ watchdog)
//   HOLD  | beat complete, o_wait high until the host releases the strobe
//
module wbdepp_burst #(
    parameter int PW      = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int AUTOINC = 1,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_astb_n,
    input  logic           i_dstb_n,
    input  logic           i_write_n,
    input  logic [PW-1:0]  i_depp,
    output logic [PW-1:0]  o_depp,
    output logic           o_wait,
    input  logic           i_int,
    wbdepp_burst_if.master wb
);

    localparam int            NB        = DW / PW;
    localparam int            BW        = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    localparam bit            INC       = (AUTOINC != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Strobe / direction / interrupt synchronizers
    logic r_astb_s1, r_astb_s2, r_astb_d;
    logic r_dstb_s1, r_dstb_s2, r_dstb_d;
    logic r_wr_s1, r_wr_s2;
    logic r_int_s1, r_int_s2;

    // Datapath
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rd_shift;
    logic [3:0]    r_status;
    logic          r_sel_status;
    logic [BW-1:0] r_beat_cnt;
    logic          r_err;
    logic          r_word_err;
    logic          r_bus_last;
    logic          r_beat_astb;

    logic          w_astb_fall;
    logic          w_dstb_fall;
    logic          w_abeat;
    logic          w_dbeat;
    logic          w_host_wr;
    logic          w_dbeat_bus;
    logic          w_strobe_high;
    logic          w_bus_resp;
    logic          w_bus_fail;
    logic          w_timeout;
    logic          w_bus_start;
    logic          w_bus_end;
    logic [BW-1:0] w_cnt_next;
    logic [3:0]    w_status;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_astb_s1 <= 1'b1;
            r_astb_s2 <= 1'b1;
            r_astb_d  <= 1'b1;
            r_dstb_s1 <= 1'b1;
            r_dstb_s2 <= 1'b1;
            r_dstb_d  <= 1'b1;
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_int_s1  <= 1'b0;
            r_int_s2  <= 1'b0;
        end else begin
            r_astb_s1 <= i_astb_n;
            r_astb_s2 <= r_astb_s1;
            r_astb_d  <= r_astb_s2;
            r_dstb_s1 <= i_dstb_n;
            r_dstb_s2 <= r_dstb_s1;
            r_dstb_d  <= r_dstb_s2;
            r_wr_s1   <= i_write_n;
            r_wr_s2   <= r_wr_s1;
            r_int_s1  <= i_int;
            r_int_s2  <= r_int_s1;
        end
    end

    assign w_astb_fall = r_astb_d & ~r_astb_s2;
    assign w_dstb_fall = r_dstb_d & ~r_dstb_s2;

    // With both strobes low the address strobe wins; a data beat is only
    // taken while the synchronized address strobe is high.
    assign w_abeat   = w_astb_fall;
    assign w_dbeat   = w_dstb_fall & r_astb_s2;
    assign w_host_wr = ~r_wr_s2;

    // Writes hit the bus on the last beat of a word, reads on the first.
    assign w_dbeat_bus = w_host_wr ? (r_beat_cnt == LAST_BEAT) : (r_beat_cnt == '0);

    assign w_strobe_high = r_beat_astb ? r_astb_s2 : r_dstb_s2;
    assign w_cnt_next    = (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BW'(1);
    assign w_status      = {(r_beat_cnt != '0), r_int_s2, r_err, r_cyc};

    assign w_bus_resp = wb.i_wb_ack | wb.i_wb_err;
    // ack together with err is treated as an error
    assign w_bus_fail = wb.i_wb_err | w_timeout;

`ifdef WBDEPP_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 255) ? 16 : 8;

    logic [TW-1:0] r_to_cnt;

    // Loaded with TIMEOUT-1 on BUS entry; reaching zero with no response
    // still pending closes the cycle TIMEOUT clocks after it opened.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_bus_start) begin
            r_to_cnt <= TW'(TIMEOUT - 1);
        end else if (r_state == ST_BUS && r_to_cnt != '0) begin
            r_to_cnt <= r_to_cnt - TW'(1);
        end
    end

    assign w_timeout = (r_state == ST_BUS) && (r_to_cnt == '0) && !w_bus_resp;
`else
    // Watchdog not built: TIMEOUT has no effect and this is constant 0.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_start = 1'b0;
        w_bus_end   = 1'b0;
        o_wait      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_abeat) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_dbeat) begin
                    if (w_dbeat_bus) begin
                        w_state_nxt = ST_BUS;
                        w_bus_start = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_BUS: begin
                if (w_bus_resp || w_timeout) begin
                    w_state_nxt = ST_HOLD;
                    w_bus_end   = 1'b1;
                end
            end
            ST_HOLD: begin
                // o_wait falls in the same cycle the released strobe is seen
                if (w_strobe_high) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    o_wait = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_shift   <= '0;
            r_status     <= '0;
            r_sel_status <= 1'b0;
            r_beat_cnt   <= '0;
            r_err        <= 1'b0;
            r_word_err   <= 1'b0;
            r_bus_last   <= 1'b0;
            r_beat_astb  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_abeat) begin
                r_beat_astb <= 1'b1;
                if (w_host_wr) begin
                    r_addr     <= AW'({r_addr, i_depp});
                    r_beat_cnt <= '0;
                end else begin
                    r_status     <= w_status;
                    r_sel_status <= 1'b1;
                    r_err        <= 1'b0;
                end
            end else if (r_state == ST_IDLE && w_dbeat) begin
                r_beat_astb <= 1'b0;
                r_beat_cnt  <= w_cnt_next;
                if (w_host_wr) begin
                    r_wdata <= DW'({r_wdata, i_depp});
                end else begin
                    r_sel_status <= 1'b0;
                    if (r_beat_cnt != '0) begin
                        r_rd_shift <= r_rd_shift << PW;
                        // A word whose bus read failed never advances the address
                        if (INC && r_beat_cnt == LAST_BEAT && !r_word_err) begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                if (w_bus_start) begin
                    r_cyc      <= 1'b1;
                    r_stb      <= 1'b1;
                    r_we       <= w_host_wr;
                    r_bus_last <= (r_beat_cnt == LAST_BEAT);
                    r_word_err <= 1'b0;
                end
            end

            if (r_state == ST_BUS) begin
                if (r_stb && !wb.i_wb_stall) begin
                    r_stb <= 1'b0;
                end
                if (w_bus_end) begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    if (w_bus_fail) begin
                        r_err      <= 1'b1;
                        r_word_err <= 1'b1;
                        if (!r_we) begin
                            r_rd_shift <= '0;
                        end
                    end else begin
                        if (!r_we) begin
                            r_rd_shift <= wb.i_wb_data;
                        end
                        if (INC && r_bus_last) begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
            end
        end
    end

    assign o_depp = r_sel_status ? PW'(r_status) : r_rd_shift[DW-1 -: PW];

    assign wb.o_wb_cyc  = r_cyc;
    assign wb.o_wb_stb  = r_stb;
    assign wb.o_wb_we   = r_we;
    assign wb.o_wb_addr = r_addr;
    assign wb.o_wb_data = r_wdata;

endmodule

// File: tb/tb_wbdepp_burst.sv
// -----------------------------------------------------------------------------
// tb_wbdepp_burst
//   Directed bench for wbdepp_burst (PW=8, AW=32, DW=32, AUTOINC=1,
//   TIMEOUT=16). A small WB slave model answers bus cycles; expected bus
//   requests and expected host read bytes are queued as stimulus is issued
//   and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_wbdepp_burst;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
    } wb_req_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       astb_n;
    logic       dstb_n;
    logic       write_n;
    logic [7:0] depp_in;
    logic [7:0] depp_out;
    logic       wait_o;
    logic       int_i;

    wb_req_t    q_wb[$];
    logic [7:0] q_depp[$];

    int n_pass     = 0;
    int n_total    = 0;
    int n_wb_req   = 0;
    int sl_stall_n = 0;
    int sl_mode    = 0;   // 0 ack, 1 err, 2 no response
    int sl_cnt     = 0;
    bit sl_acc     = 1'b0;
    logic [31:0] sl_rdata = 32'h0;

    always #5 clk = ~clk;

    wbdepp_burst_if #(.AW(32), .DW(32)) wb ();

    wbdepp_burst #(
        .PW(8), .AW(32), .DW(32), .AUTOINC(1), .TIMEOUT(16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_astb_n  (astb_n),
        .i_dstb_n  (dstb_n),
        .i_write_n (write_n),
        .i_depp    (depp_in),
        .o_depp    (depp_out),
        .o_wait    (wait_o),
        .i_int     (int_i),
        .wb        (wb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wb_request_check();
        wb_req_t e;
        n_wb_req++;
        chk("wb_req_expected", (q_wb.size() > 0), 1);
        if (q_wb.size() > 0) begin
            e = q_wb.pop_front();
            chk("wb_req_we", wb.o_wb_we, e.we);
            chk("wb_req_addr", wb.o_wb_addr, e.addr);
            if (e.chk_data) chk("wb_req_data", wb.o_wb_data, e.data);
        end
    endtask

    // WB slave: stall sl_stall_n clocks, accept, then respond next clock
    always @(negedge clk) begin
        wb.i_wb_ack = 1'b0;
        wb.i_wb_err = 1'b0;
        if (!wb.o_wb_cyc) begin
            wb.i_wb_stall = 1'b0;
            sl_cnt = 0;
            sl_acc = 1'b0;
        end else if (wb.o_wb_stb) begin
            if (sl_cnt < sl_stall_n) begin
                wb.i_wb_stall = 1'b1;
                sl_cnt++;
            end else begin
                wb.i_wb_stall = 1'b0;
                sl_acc = 1'b1;
                wb_request_check();
            end
        end else if (sl_acc) begin
            sl_acc = 1'b0;
            if (sl_mode == 0) begin
                wb.i_wb_ack  = 1'b1;
                wb.i_wb_data = sl_rdata;
            end else if (sl_mode == 1) begin
                wb.i_wb_err = 1'b1;
            end
        end
    end

    // kind: 0 address strobe, 1 data strobe, 2 both strobes together
    task automatic host_beat(input int kind, input bit wr, input logic [7:0] d,
                             output logic [7:0] rd);
        int k;
        @(negedge clk);
        write_n = ~wr;
        depp_in = d;
        if (kind != 1) astb_n = 1'b0;
        if (kind != 0) dstb_n = 1'b0;
        k = 0;
        while (!wait_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wait_rise", wait_o, 1);
        chk("bus_closed_at_wait", wb.o_wb_cyc, 0);
        rd = depp_out;
        astb_n = 1'b1;
        dstb_n = 1'b1;
        k = 0;
        while (wait_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wait_fall", wait_o, 0);
        @(negedge clk);
    endtask

    task automatic rd_beat();
        logic [7:0] rd;
        host_beat(1, 1'b0, 8'h00, rd);
        chk("rd_expected", (q_depp.size() > 0), 1);
        if (q_depp.size() > 0) chk("rd_data", rd, q_depp.pop_front());
    endtask

    initial begin
        logic [7:0] rd;
        int k;
        rst_n   = 1'b0;
        astb_n  = 1'b1;
        dstb_n  = 1'b1;
        write_n = 1'b1;
        depp_in = 8'h00;
        int_i   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cyc", wb.o_wb_cyc, 0);
        chk("rst_stb", wb.o_wb_stb, 0);
        chk("rst_we", wb.o_wb_we, 0);
        chk("rst_addr", wb.o_wb_addr, 0);
        chk("rst_data", wb.o_wb_data, 0);
        chk("rst_depp", depp_out, 0);
        chk("rst_wait", wait_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Address load, MSB beat first
        host_beat(0, 1'b1, 8'h00, rd);
        host_beat(0, 1'b1, 8'h00, rd);
        host_beat(0, 1'b1, 8'h01, rd);
        host_beat(0, 1'b1, 8'h20, rd);
        chk("addr_load", wb.o_wb_addr, 32'h0000_0120);
        chk("addr_no_wb", n_wb_req, 0);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("status_idle", rd, 8'h00);

        // Word write with 2 stall clocks; status read mid-word
        sl_mode    = 0;
        sl_stall_n = 2;
        q_wb.push_back('{we: 1'b1, addr: 32'h120, data: 32'hDEAD_BEEF, chk_data: 1'b1});
        host_beat(1, 1'b1, 8'hDE, rd);
        host_beat(1, 1'b1, 8'hAD, rd);
        int_i = 1'b1;
        repeat (3) @(negedge clk);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("status_midword", rd, 8'h0C);
        int_i = 1'b0;
        host_beat(1, 1'b1, 8'hBE, rd);
        chk("wr_no_early_wb", n_wb_req, 0);
        host_beat(1, 1'b1, 8'hEF, rd);
        chk("wr_one_cycle", n_wb_req, 1);
        chk("wr_data", wb.o_wb_data, 32'hDEAD_BEEF);
        chk("wr_we", wb.o_wb_we, 1);
        chk("wr_addr_inc", wb.o_wb_addr, 32'h0000_0121);

        // Word read: one bus access on the first beat
        sl_stall_n = 0;
        sl_rdata   = 32'h1234_5678;
        q_wb.push_back('{we: 1'b0, addr: 32'h121, data: 32'h0, chk_data: 1'b0});
        q_depp.push_back(8'h12);
        q_depp.push_back(8'h34);
        q_depp.push_back(8'h56);
        q_depp.push_back(8'h78);
        for (int i = 0; i < 4; i++) rd_beat();
        chk("rd_one_cycle", n_wb_req, 2);
        chk("rd_addr_inc", wb.o_wb_addr, 32'h0000_0122);

        // Read that errors: zeros returned, address held, sticky err
        sl_mode  = 1;
        sl_rdata = 32'hAAAA_AAAA;
        q_wb.push_back('{we: 1'b0, addr: 32'h122, data: 32'h0, chk_data: 1'b0});
        for (int i = 0; i < 4; i++) q_depp.push_back(8'h00);
        for (int i = 0; i < 4; i++) rd_beat();
        chk("err_addr_held", wb.o_wb_addr, 32'h0000_0122);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("status_err", rd, 8'h02);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("status_err_cleared", rd, 8'h00);
        sl_mode = 0;

        // Address wrap on auto-increment
        for (int i = 0; i < 4; i++) host_beat(0, 1'b1, 8'hFF, rd);
        chk("addr_all_ones", wb.o_wb_addr, 32'hFFFF_FFFF);
        q_wb.push_back('{we: 1'b1, addr: 32'hFFFF_FFFF, data: 32'h0102_0304, chk_data: 1'b1});
        host_beat(1, 1'b1, 8'h01, rd);
        host_beat(1, 1'b1, 8'h02, rd);
        host_beat(1, 1'b1, 8'h03, rd);
        host_beat(1, 1'b1, 8'h04, rd);
        chk("addr_wrap", wb.o_wb_addr, 32'h0000_0000);

        // Both strobes low: address beat taken, data beat dropped
        host_beat(2, 1'b1, 8'h55, rd);
        chk("both_addr", wb.o_wb_addr, 32'h0000_0055);
        chk("both_data_kept", wb.o_wb_data, 32'h0102_0304);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("both_status", rd, 8'h00);
        chk("both_wb_count", n_wb_req, 4);

        // Reset while a WB cycle is open
        sl_mode    = 2;
        sl_stall_n = 1000;
        @(negedge clk);
        write_n = 1'b1;
        dstb_n  = 1'b0;
        k = 0;
        while (!wb.o_wb_cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("hang_bus_entered", wb.o_wb_cyc, 1);
`ifdef WBDEPP_TIMEOUT_EN
        repeat (5) @(negedge clk);
`else
        repeat (40) @(negedge clk);
`endif
        chk("hang_cyc_open", wb.o_wb_cyc, 1);
        chk("hang_stb_open", wb.o_wb_stb, 1);
        chk("hang_wait_low", wait_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", wb.o_wb_cyc, 0);
        chk("rst_mid_stb", wb.o_wb_stb, 0);
        chk("rst_mid_wait", wait_o, 0);
        dstb_n     = 1'b1;
        sl_mode    = 0;
        sl_stall_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rel_addr", wb.o_wb_addr, 32'h0);
        host_beat(0, 1'b0, 8'h00, rd);
        chk("rst_rel_status", rd, 8'h00);

`ifdef WBDEPP_TIMEOUT_EN
        // Watchdog: no response, cycle closes 16 clocks after it opened
        sl_mode    = 2;
        sl_stall_n = 0;
        q_wb.push_back('{we: 1'b0, addr: 32'h0, data: 32'h0, chk_data: 1'b0});
        @(negedge clk);
        write_n = 1'b1;
        dstb_n  = 1'b0;
        k = 0;
        while (!wb.o_wb_cyc && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_bus_entered", wb.o_wb_cyc, 1);
        k = 0;
        while (wb.o_wb_cyc && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("to_clocks", k, 16);
        chk("to_stb", wb.o_wb_stb, 0);
        k = 0;
        while (!wait_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_wait", wait_o, 1);
        chk("to_depp", depp_out, 8'h00);
        dstb_n = 1'b1;
        k = 0;
        while (wait_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_wait_fall", wait_o, 0);
        sl_mode = 0;
        host_beat(0, 1'b0, 8'h00, rd);
        chk("to_status", rd, 8'h0A);
        chk("to_addr_held", wb.o_wb_addr, 32'h0);
`endif

        chk("wb_queue_drained", q_wb.size(), 0);
        chk("rd_queue_drained", q_depp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
